cmd_uart_decoder: RTL and testbench
===================================

Name: cmd_uart_decoder

Overview:
Host command front-end for the glitcher. It receives 8N1 UART bytes from the host PC and decodes short command frames. Its outputs drive the controller-side control nets: delay value, set_delay strobe, trigger/success arm strobes, and target soft/hard reset requests. It sits directly upstream of the controller, trigger_delay and target_control_* stages, in the clk domain.

Parameters:
CLKS_PER_BIT, 278, clk cycles per UART bit (32 MHz / 115200, rounded).
TIMEOUT_CYCLES, 320000, inter-byte timeout inside a frame (10 ms at 32 MHz).
DEFAULT_DELAY, 0, value of delay after reset.

Ports:
clk  input  1  system clock, 32 MHz
rst  input  1  asynchronous active-low reset
rx  input  1  UART receive line from host, idle high, asynchronous to clk
tx  output  1  UART transmit line to host, idle high
delay  output  32  programmed trigger delay, in target clock cycles
set_delay  output  1  one-cycle strobe when delay has been updated
trigger_arm  output  1  one-cycle strobe
success_arm  output  1  one-cycle strobe
target_soft_reset  output  1  one-cycle strobe
target_hard_reset  output  1  one-cycle strobe
cmd_error  output  1  one-cycle strobe on a framing error, unknown opcode or timeout

Behaviour:
- Reset, asynchronous and active-low, puts the block in this state:
  - all strobes = 0, tx = 1
  - delay = DEFAULT_DELAY
  - rx synchroniser flops = 1
  - receiver and parser in IDLE, timeout counter = 0
- rx path: 2-flop synchroniser. All behaviour below uses the synchronised rx.
- Receiver FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a synchronised 1->0 transition enters RX_START.
  - RX_START: sample at CLKS_PER_BIT/2 (integer divide). If the sample is 1, the start is false; return to RX_IDLE with no error.
  - RX_DATA: 8 samples at CLKS_PER_BIT intervals, LSB first.
  - RX_STOP: one sample. If 1, raise internal byte_valid for 1 cycle (cycle T). If 0, it is a framing error: drop the byte, pulse cmd_error at T+1, and abort any partial frame.
- Parser FSM states: P_IDLE, P_DLY0..P_DLY3.
  - In P_IDLE, an opcode byte arriving at T produces its strobe at T+1, high for exactly 1 cycle:
    - 0x41 'A' -> trigger_arm
    - 0x53 'S' -> success_arm
    - 0x52 'R' -> target_soft_reset
    - 0x50 'P' -> target_hard_reset
    - 0x44 'D' -> go to P_DLY0
    - any other byte -> cmd_error
  - P_DLY0..P_DLY3 each accept one payload byte, big-endian, into a 32-bit shadow register.
  - After the byte in P_DLY3: delay <= shadow at T+1, set_delay = 1 at T+1, return to P_IDLE.
  - delay never changes on a partial frame.
- Timeout:
  - The counter runs only while the parser is in P_DLY*, and clears on every byte_valid.
  - Reaching TIMEOUT_CYCLES-1 aborts the frame: cmd_error pulse, go to P_IDLE, shadow discarded.
  - If byte_valid and timeout expiry fall in the same cycle, the byte wins: it is accepted and the counter clears.
- Bytes received while a strobe is high are handled normally. At most one strobe can be active per cycle, since bytes are at least 10 bit-times apart.
- Reset mid-frame discards everything. No strobe is emitted during or immediately after reset.

Optional Feature:
CMD_UART_ACK_EN
- Defined: adds a UART transmitter with the same CLKS_PER_BIT and 8N1 format.
  - Sends 0x4B 'K' after every accepted command, starting in the cycle its strobe fires.
  - Sends 0x3F '?' after every cmd_error.
  - One-entry pending slot. If a new ack arrives while a byte is being sent, the newest ack overwrites the slot; the byte in flight is never corrupted.
- Not defined: tx is tied to 1, and no transmitter logic is built.

Test Plan:
- Send 0x44,0x00,0x00,0x01,0x2C -> delay = 300; set_delay high for exactly 1 cycle, 1 cycle after the last stop-bit sample; no other strobe.
- Send 0x41, then 0x50 -> one trigger_arm pulse, then one target_hard_reset pulse, each 1 cycle wide; delay unchanged.
- Send 0x44,0x12, then idle for TIMEOUT_CYCLES+10 cycles -> one cmd_error pulse; delay keeps its old value. A following 0x53 then gives success_arm.
- Send 0x7A -> cmd_error pulse. Send a byte with stop bit = 0 -> cmd_error, no strobe. A 0.3-bit-time low glitch on rx -> no byte, no error.
- Assert rst low in the middle of the third payload byte of a 'D' frame -> all outputs at their reset values, delay = DEFAULT_DELAY. After release, a full 'D' frame decodes correctly.
- With CMD_UART_ACK_EN defined: send 0x52 -> tx carries 0x4B 8N1 at CLKS_PER_BIT timing. Send 0x00 -> tx carries 0x3F.

Source files
------------

// File: rtl/cmd_uart_decoder.sv
// Host command front-end: 8N1 UART receiver plus frame parser driving glitcher control strobes.
// Define CMD_UART_ACK_EN to build the ack transmitter ('K' on accept, '?' on error); otherwise tx idles high.
module cmd_uart_decoder #(
    parameter int unsigned CLKS_PER_BIT   = 278,
    parameter int unsigned TIMEOUT_CYCLES = 320000,
    parameter logic [31:0] DEFAULT_DELAY  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] delay,
    output logic        set_delay,
    output logic        trigger_arm,
    output logic        success_arm,
    output logic        target_soft_reset,
    output logic        target_hard_reset,
    output logic        cmd_error
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_DLY0, P_DLY1, P_DLY2, P_DLY3} p_state_t;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          byte_vld, frame_err;

    p_state_t      p_state_q, p_state_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [31:0]   delay_q, delay_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          set_delay_q, set_delay_d;
    logic          trig_q, trig_d;
    logic          succ_q, succ_d;
    logic          soft_q, soft_d;
    logic          hard_q, hard_d;
    logic          err_q, err_d;

    // Receiver: all decisions use the second synchroniser stage.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_vld   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                byte_vld   = rx_s2_q;
                frame_err  = !rx_s2_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Parser: a byte arriving together with timeout expiry takes priority.
    always_comb begin
        p_state_d   = p_state_q;
        shadow_d    = shadow_q;
        delay_d     = delay_q;
        tmo_d       = '0;
        set_delay_d = 1'b0;
        trig_d      = 1'b0;
        succ_d      = 1'b0;
        soft_d      = 1'b0;
        hard_d      = 1'b0;
        err_d       = 1'b0;
        if (frame_err) begin
            p_state_d = P_IDLE;
            err_d     = 1'b1;
        end else if (byte_vld) begin
            case (p_state_q)
                P_IDLE: begin
                    case (rx_shift_q)
                        8'h41:   trig_d = 1'b1;
                        8'h53:   succ_d = 1'b1;
                        8'h52:   soft_d = 1'b1;
                        8'h50:   hard_d = 1'b1;
                        8'h44: begin
                            p_state_d = P_DLY0;
                            shadow_d  = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                P_DLY0: begin
                    shadow_d[23:16] = rx_shift_q;
                    p_state_d       = P_DLY1;
                end
                P_DLY1: begin
                    shadow_d[15:8] = rx_shift_q;
                    p_state_d      = P_DLY2;
                end
                P_DLY2: begin
                    shadow_d[7:0] = rx_shift_q;
                    p_state_d     = P_DLY3;
                end
                P_DLY3: begin
                    delay_d     = {shadow_q, rx_shift_q};
                    set_delay_d = 1'b1;
                    p_state_d   = P_IDLE;
                end
                default: p_state_d = P_IDLE;
            endcase
        end else if (p_state_q != P_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                p_state_d = P_IDLE;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            p_state_q   <= P_IDLE;
            shadow_q    <= '0;
            delay_q     <= DEFAULT_DELAY;
            tmo_q       <= '0;
            set_delay_q <= 1'b0;
            trig_q      <= 1'b0;
            succ_q      <= 1'b0;
            soft_q      <= 1'b0;
            hard_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            p_state_q   <= p_state_d;
            shadow_q    <= shadow_d;
            delay_q     <= delay_d;
            tmo_q       <= tmo_d;
            set_delay_q <= set_delay_d;
            trig_q      <= trig_d;
            succ_q      <= succ_d;
            soft_q      <= soft_d;
            hard_q      <= hard_d;
            err_q       <= err_d;
        end
    end

    assign delay             = delay_q;
    assign set_delay         = set_delay_q;
    assign trigger_arm       = trig_q;
    assign success_arm       = succ_q;
    assign target_soft_reset = soft_q;
    assign target_hard_reset = hard_q;
    assign cmd_error         = err_q;

`ifdef CMD_UART_ACK_EN
    logic          ack_req, tx_free;
    logic [7:0]    ack_byte, tx_byte;
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    pend_byte_q, pend_byte_d;

    assign ack_req  = trig_d | succ_d | soft_d | hard_d | set_delay_d | err_d;
    assign ack_byte = err_d ? 8'h3F : 8'h4B;

    // The newest ack always wins the slot; the frame on the wire is never touched.
    always_comb begin
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        tx_shift_d  = tx_shift_q;
        tx_bits_d   = tx_bits_q;
        tx_cnt_d    = tx_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_byte_d = pend_byte_q;
        tx_free     = !tx_busy_q || (tx_cnt_q == BIT_LAST && tx_bits_q == 4'd0);
        tx_byte     = ack_req ? ack_byte : pend_byte_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bits_q == 4'd0) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[8:1]};
                    tx_bits_d  = tx_bits_q - 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
        if (tx_free && (ack_req || pend_vld_q)) begin
            tx_d       = 1'b0;
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_byte};
            tx_bits_d  = 4'd9;
            tx_cnt_d   = '0;
            pend_vld_d = 1'b0;
        end else if (ack_req) begin
            pend_vld_d  = 1'b1;
            pend_byte_d = ack_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_shift_q  <= '1;
            tx_bits_q   <= '0;
            tx_cnt_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_byte_q <= '0;
        end else begin
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            tx_shift_q  <= tx_shift_d;
            tx_bits_q   <= tx_bits_d;
            tx_cnt_q    <= tx_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    assign tx = tx_q;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_cmd_uart_decoder.sv
// Directed bench for cmd_uart_decoder with shortened bit time and timeout.
module tb_cmd_uart_decoder;
    localparam int          CPB = 16;
    localparam int          TMO = 2000;
    localparam logic [31:0] DEF = 32'h0000_1234;
    // Start-bit drive to registered strobe: 2 sync + 1 edge + CPB/2 + 9*CPB.
    localparam int          LAT = 3 + CPB / 2 + 9 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] delay;
    logic        set_delay, trigger_arm, success_arm;
    logic        target_soft_reset, target_hard_reset, cmd_error;

    cmd_uart_decoder #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TMO),
        .DEFAULT_DELAY (DEF)
    ) dut (
        .clk              (clk),
        .rst              (rst_n),
        .rx               (rx),
        .tx               (tx),
        .delay            (delay),
        .set_delay        (set_delay),
        .trigger_arm      (trigger_arm),
        .success_arm      (success_arm),
        .target_soft_reset(target_soft_reset),
        .target_hard_reset(target_hard_reset),
        .cmd_error        (cmd_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [5:0] stb, stb_prev = '0;
    assign stb = {cmd_error, target_hard_reset, target_soft_reset,
                  success_arm, trigger_arm, set_delay};
    string stb_name[6] = '{"set_delay", "trigger_arm", "success_arm",
                           "soft_reset", "hard_reset", "cmd_error"};

    int cnt[6]      = '{default: 0};
    int last_cyc[6] = '{default: -1};
    int base[6];
    int wide_cnt = 0, multi_cnt = 0, tx_low = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (stb[i] === 1'b1) begin
                cnt[i]++;
                last_cyc[i] = cyc;
                if (stb_prev[i] === 1'b1) wide_cnt++;
            end
        end
        if ($countones(stb) > 1) multi_cnt++;
        if (tx !== 1'b1) tx_low++;
        stb_prev = stb;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 6; i++) base[i] = cnt[i];
    endtask

    task automatic check_deltas(input string tag, input int exp_idx, input int exp_cyc);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s %s count", tag, stb_name[i]), 64'(cnt[i] - base[i]),
                  (i == exp_idx) ? 64'd1 : 64'd0);
        if (exp_idx >= 0)
            check({tag, " timing"}, 64'(last_cyc[exp_idx]), 64'(exp_cyc));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int s);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        s = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send_delay(input logic [31:0] v, output int s);
        send_byte(8'h44, 1'b1, s);
        send_byte(v[31:24], 1'b1, s);
        send_byte(v[23:16], 1'b1, s);
        send_byte(v[15:8], 1'b1, s);
        send_byte(v[7:0], 1'b1, s);
    endtask

`ifdef CMD_UART_ACK_EN
    task automatic tx_capture(output logic [7:0] b, output int c);
        int t;
        t = 0;
        b = '0;
        c = -1;
        while (tx !== 1'b0 && t < 40 * CPB) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            check("tx start bit seen", 64'(tx), 64'd0);
        end else begin
            c = cyc;
            repeat (CPB / 2) @(negedge clk);
            check("tx start bit mid", 64'(tx), 64'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("tx stop bit", 64'(tx), 64'd1);
        end
    endtask
`endif

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_idx;
        string      name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vecs[0] = '{8'h41, 1'b1, 1, "op A"};
        vecs[1] = '{8'h50, 1'b1, 4, "op P"};
        vecs[2] = '{8'h53, 1'b1, 2, "op S"};
        vecs[3] = '{8'h52, 1'b1, 3, "op R"};
        vecs[4] = '{8'h7A, 1'b1, 5, "op 0x7A"};
        vecs[5] = '{8'h00, 1'b1, 5, "op 0x00"};
        vecs[6] = '{8'h41, 1'b0, 5, "A bad stop"};
        vecs[7] = '{8'hFF, 1'b1, 5, "op 0xFF"};

        repeat (3) @(negedge clk);
        check("reset delay", 64'(delay), 64'(DEF));
        check("reset strobes", 64'(stb), 64'd0);
        check("reset tx", 64'(tx), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        snap();
        send_delay(32'd300, s);
        repeat (8) @(posedge clk);
        check("D frame delay", 64'(delay), 64'd300);
        check_deltas("D frame", 0, s + LAT);

        foreach (vecs[k]) begin
            snap();
            send_byte(vecs[k].b, vecs[k].stop, s);
            repeat (8) @(posedge clk);
            check_deltas(vecs[k].name, vecs[k].exp_idx, s + LAT);
        end
        check("delay after opcodes", 64'(delay), 64'd300);

        snap();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        check_deltas("glitch", -1, 0);

        snap();
        send_byte(8'h44, 1'b1, s);
        send_byte(8'h12, 1'b1, s);
        repeat (TMO + 10) @(posedge clk);
        check_deltas("timeout", 5, s + LAT + TMO);
        check("timeout delay kept", 64'(delay), 64'd300);
        snap();
        send_byte(8'h53, 1'b1, s);
        repeat (8) @(posedge clk);
        check_deltas("S after timeout", 2, s + LAT);

        snap();
        send_byte(8'h44, 1'b1, s);
        send_byte(8'hDE, 1'b1, s);
        send_byte(8'hAD, 1'b1, s);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid reset delay", 64'(delay), 64'(DEF));
        check("mid reset strobes", 64'(stb), 64'd0);
        check("mid reset tx", 64'(tx), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        check_deltas("around reset", -1, 0);
        check("delay after reset", 64'(delay), 64'(DEF));
        snap();
        send_delay(32'hDEAD_BEEF, s);
        repeat (8) @(posedge clk);
        check("post reset frame delay", 64'(delay), 64'hDEAD_BEEF);
        check_deltas("post reset frame", 0, s + LAT);

`ifdef CMD_UART_ACK_EN
        begin
            logic [7:0] b;
            int         c;
            repeat (30 * CPB) @(posedge clk);
            snap();
            fork
                send_byte(8'h52, 1'b1, s);
                tx_capture(b, c);
            join
            check("ack K byte", 64'(b), 64'h4B);
            check("ack K start cycle", 64'(c), 64'(last_cyc[3]));
            repeat (2 * CPB) @(posedge clk);
            fork
                send_byte(8'h00, 1'b1, s);
                tx_capture(b, c);
            join
            check("ack ? byte", 64'(b), 64'h3F);
            check("ack ? start cycle", 64'(c), 64'(last_cyc[5]));
        end
`else
        check("tx idle throughout", 64'(tx_low), 64'd0);
`endif

        check("strobe width", 64'(wide_cnt), 64'd0);
        check("one strobe per cycle", 64'(multi_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
